// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
// Holds the FSM state encoding, bus widths and the key-code encode function.
package keypad_pkg;

    localparam int COL_W  = 4;
    localparam int ROW_W  = 4;
    localparam int CODE_W = 4;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    function automatic logic [CODE_W-1:0] encode_key(
        input logic [IDX_W-1:0] col_idx,
        input logic [IDX_W-1:0] row_idx
    );
        return {col_idx, row_idx};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key codes; head entry is shown combinationally.
// Pointers carry a wrap bit so full and empty are told apart by the MSB.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CODE_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push while full is accepted then.
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge Clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: strobes columns, debounces press/release on the
// sample tick, and queues one 4-bit code per key press for a Valid/Ready consumer.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ROW_W-1:0]  S_Row,
    output logic [COL_W-1:0]  Col,
    output logic [CODE_W-1:0] Code,
    output logic              Valid,
    input  logic              Ready,
    output logic              Overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DBC_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE_CNT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [IDX_W-1:0] r_col_idx;
    logic [IDX_W-1:0] w_col_nxt;
    logic [IDX_W-1:0] r_row_idx;
    logic [IDX_W-1:0] w_row_nxt;
    logic [DBC_W-1:0] r_dbc;
    logic [DBC_W-1:0] w_dbc_nxt;
    logic [DBC_W-1:0] w_dbc_inc;
    logic             r_overflow;

    logic             w_tick;
    logic             w_row_any;
    logic [IDX_W-1:0] w_row_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_row_any = ~&S_Row;
    assign w_dbc_inc = r_dbc + 1'b1;

    // Scanning downward lets the lowest closed row overwrite any higher one.
    always_comb begin
        w_row_idx = '0;
        for (int i = ROW_W - 1; i >= 0; i--) begin
            if (!S_Row[i]) w_row_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div      <= '0;
            r_state    <= SCAN;
            r_col_idx  <= '0;
            r_row_idx  <= '0;
            r_dbc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_div      <= w_tick ? '0 : r_div + 1'b1;
            r_state    <= w_state_nxt;
            r_col_idx  <= w_col_nxt;
            r_row_idx  <= w_row_nxt;
            r_dbc      <= w_dbc_nxt;
            r_overflow <= w_push && w_full && !w_pop;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_dbc_nxt   = r_dbc;
        w_push      = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_row_any) begin
                        w_row_nxt   = w_row_idx;
                        w_dbc_nxt   = DBC_W'(1);
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col_idx + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_row_any && (w_row_idx == r_row_idx)) begin
                        if (w_dbc_inc == DBC_DONE) begin
                            w_push      = 1'b1;
                            w_dbc_nxt   = '0;
                            w_state_nxt = RELEASE;
                        end else begin
                            w_dbc_nxt = w_dbc_inc;
                        end
                    end else begin
                        w_dbc_nxt   = '0;
                        w_state_nxt = SCAN;
                    end
                end
                RELEASE: begin
                    if (!w_row_any) begin
                        if (w_dbc_inc == DBC_DONE) begin
                            w_dbc_nxt   = '0;
                            w_state_nxt = SCAN;
                            w_col_nxt   = r_col_idx + 1'b1;
                        end else begin
                            w_dbc_nxt = w_dbc_inc;
                        end
                    end else begin
                        w_dbc_nxt = '0;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
    end

    assign w_pop = Valid && Ready;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_data  (encode_key(r_col_idx, r_row_idx)),
        .i_pop   (w_pop),
        .o_data  (Code),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign Col      = ~(COL_W'(1) << r_col_idx);
    assign Valid    = !w_empty;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad matrix model drives S_Row
// from the strobed column, and a scoreboard queue holds the codes expected out.
module tb_keypad_scan_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] S_Row;
    logic [3:0] Col;
    logic [3:0] Code;
    logic       Valid;
    logic       Ready;
    logic       Overflow;

    logic [3:0] key_row [4];
    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         ovf_count = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .S_Row    (S_Row),
        .Col      (Col),
        .Code     (Code),
        .Valid    (Valid),
        .Ready    (Ready),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    // Closed key at (c, r) pulls row r low only while column c is strobed.
    always_comb begin
        S_Row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (Col[c] == 1'b0) S_Row = ~key_row[c];
        end
    end

    always @(negedge Clk) begin
        if (Overflow === 1'b1) ovf_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic release_all();
        for (int c = 0; c < 4; c++) key_row[c] = 4'h0;
    endtask

    task automatic press(input int c, input int r);
        key_row[c][r] = 1'b1;
    endtask

    // Returns at the first negedge after Col switches onto column c, i.e. just
    // after a sample tick; the next two ticks fall 4 and 8 edges later.
    task automatic wait_col_edge(input int c);
        logic [3:0] prev;
        logic [3:0] tgt;
        int         t;
        tgt  = ~(4'b0001 << c);
        prev = Col;
        for (t = 0; t < 80; t++) begin
            @(negedge Clk);
            if (Col == tgt && prev != tgt) break;
            prev = Col;
        end
        n_checks++;
        if (t == 80) begin
            n_errors++;
            $display("FAIL wait_col%0d: Col=%b never switched to %b", c, Col, tgt);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Ready = 1'b0;
        release_all();
        repeat (3) @(negedge Clk);
        n_checks++;
        if (Col !== 4'b1110 || Code !== 4'h0 || Valid !== 1'b0 || Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: Col=%b Code=%h Valid=%b Overflow=%b expected 1110/0/0/0",
                     Col, Code, Valid, Overflow);
        end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        Reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge Clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            n_checks++;
            if (Col !== exp_col || Valid !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_scan%0d: Col=%b Valid=%b expected Col=%b Valid=0", k, Col, Valid, exp_col);
            end
        end
    endtask

    task automatic test_single_key();
        logic [3:0] exp;
        wait_col_edge(2);
        press(2, 1);
        exp_q.push_back(4'b1001);
        repeat (7) @(negedge Clk);
        n_checks++;
        if (Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_early: Valid=%b expected 0 before push tick", Valid);
        end
        @(negedge Clk);
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp_q[0] || Col !== 4'b1011) begin
            n_errors++;
            $display("FAIL single_latency: Valid=%b Code=%b Col=%b expected 1/%b/1011",
                     Valid, Code, Col, exp_q[0]);
        end
        repeat (32) @(negedge Clk);
        release_all();
        repeat (16) @(negedge Clk);
        Ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp) begin
            n_errors++;
            $display("FAIL single_head: Valid=%b Code=%b expected 1/%b", Valid, Code, exp);
        end
        @(negedge Clk);
        Ready = 1'b0;
        n_checks++;
        if (Valid !== 1'b0 || Code !== 4'h0) begin
            n_errors++;
            $display("FAIL single_once: Valid=%b Code=%h expected 0/0 after one pop", Valid, Code);
        end
    endtask

    task automatic test_bounce();
        wait_col_edge(3);
        press(3, 0);
        repeat (4) @(negedge Clk);
        release_all();
        repeat (4) @(negedge Clk);
        press(3, 0);
        repeat (4) @(negedge Clk);
        release_all();
        repeat (4) @(negedge Clk);
        n_checks++;
        if (Col !== 4'b0111 || Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_hold: Col=%b Valid=%b expected 0111/0", Col, Valid);
        end
        repeat (4) @(negedge Clk);
        n_checks++;
        if (Col !== 4'b1110 || Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_resume: Col=%b Valid=%b expected 1110/0", Col, Valid);
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp;
        wait_col_edge(1);
        press(1, 0);
        press(1, 3);
        exp_q.push_back(4'b0100);
        repeat (8) @(negedge Clk);
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp_q[0]) begin
            n_errors++;
            $display("FAIL priority_code: Valid=%b Code=%b expected 1/%b", Valid, Code, exp_q[0]);
        end
        repeat (8) @(negedge Clk);
        release_all();
        repeat (16) @(negedge Clk);
        Ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp) begin
            n_errors++;
            $display("FAIL priority_head: Valid=%b Code=%b expected 1/%b", Valid, Code, exp);
        end
        @(negedge Clk);
        Ready = 1'b0;
        n_checks++;
        if (Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL priority_once: Valid=%b expected 0", Valid);
        end
    endtask

    task automatic test_overflow();
        int         cols [5] = '{0, 1, 2, 3, 0};
        int         rows [5] = '{0, 1, 2, 3, 1};
        int         ovf_start;
        logic [3:0] exp;
        Ready     = 1'b0;
        ovf_start = ovf_count;
        for (int k = 0; k < 5; k++) begin
            wait_col_edge(cols[k]);
            press(cols[k], rows[k]);
            if (k < 4) exp_q.push_back({2'(cols[k]), 2'(rows[k])});
            repeat (12) @(negedge Clk);
            release_all();
        end
        repeat (12) @(negedge Clk);
        n_checks++;
        if (ovf_count - ovf_start !== 1 || Valid !== 1'b1 || Code !== exp_q[0]) begin
            n_errors++;
            $display("FAIL ovf_fill: overflow pulses=%0d Valid=%b Code=%h expected 1/1/%h",
                     ovf_count - ovf_start, Valid, Code, exp_q[0]);
        end
        // Sixth key: pop exactly on the push tick while full.
        wait_col_edge(1);
        press(1, 2);
        repeat (7) @(negedge Clk);
        Ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp) begin
            n_errors++;
            $display("FAIL ovf_pop_head: Valid=%b Code=%h expected 1/%h", Valid, Code, exp);
        end
        @(negedge Clk);
        Ready = 1'b0;
        exp_q.push_back(4'b0110);
        repeat (4) @(negedge Clk);
        release_all();
        repeat (16) @(negedge Clk);
        n_checks++;
        if (ovf_count - ovf_start !== 1) begin
            n_errors++;
            $display("FAIL ovf_pushpop: overflow pulses=%0d expected 1", ovf_count - ovf_start);
        end
        Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (Valid !== 1'b1 || Code !== exp) begin
                n_errors++;
                $display("FAIL ovf_drain%0d: Valid=%b Code=%h expected 1/%h", i, Valid, Code, exp);
            end
            @(negedge Clk);
        end
        Ready = 1'b0;
        n_checks++;
        if (Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_count4: Valid=%b expected 0 after four pops", Valid);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] exp_col;
        Ready = 1'b0;
        wait_col_edge(2);
        press(2, 0);
        exp_q.push_back(4'b1000);
        repeat (12) @(negedge Clk);
        release_all();
        wait_col_edge(3);
        press(3, 1);
        exp_q.push_back(4'b1101);
        repeat (12) @(negedge Clk);
        release_all();
        wait_col_edge(0);
        press(0, 2);
        repeat (5) @(negedge Clk);
        n_checks++;
        if (Valid !== 1'b1 || Code !== exp_q[0]) begin
            n_errors++;
            $display("FAIL rst_pre: Valid=%b Code=%h expected 1/%h", Valid, Code, exp_q[0]);
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (Valid !== 1'b0 || Col !== 4'b1110 || Code !== 4'h0 || Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_async: Valid=%b Col=%b Code=%h Overflow=%b expected 0/1110/0/0",
                     Valid, Col, Code, Overflow);
        end
        release_all();
        exp_q.delete();
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            n_checks++;
            if (Col !== exp_col || Valid !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_restart%0d: Col=%b Valid=%b expected %b/0", k, Col, Valid, exp_col);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_key();
        test_bounce();
        test_priority();
        test_overflow();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
